// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 4-bit Fibonacci LFSR generator/checker pair.
package lfsr_pkg;

  typedef enum logic {StSeed, StCheck} lfsr_state_e;

  localparam int unsigned LfsrWidth = 4;
  localparam logic [LfsrWidth-1:0] LfsrTaps = 4'b1100;
  localparam logic [LfsrWidth-1:0] LfsrSeed = 4'hF;

  function automatic logic lfsr_next_bit(logic [LfsrWidth-1:0] state,
                                         logic [LfsrWidth-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_pred.sv
// Shadow register and XOR feedback prediction; shifts in either the received or the
// predicted bit so that a single corrupted bit does not pollute later predictions.
module lfsr_pred #(
  parameter int unsigned     Width = 4,
  parameter logic [Width-1:0] Taps = 4'b1100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic             use_pred_i,
  input  logic             bit_i,
  output logic [Width-1:0] shadow_o,
  output logic             pred_o
);

  logic [Width-1:0] shadow_q, shadow_d;
  logic             src_bit;

  assign pred_o   = ^(shadow_q & Taps);
  assign src_bit  = use_pred_i ? pred_o : bit_i;
  assign shadow_o = shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (clear_i) begin
      shadow_d = '0;
    end else if (shift_i) begin
      shadow_d = {shadow_q[Width-2:0], src_bit};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial LFSR error checker. Optional macro LFSR_CHK_BITCNT_EN adds
// bit_count_o (bits checked while locked) and resync_count_o (lock losses).
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      Width     = 4,
  parameter logic [Width-1:0] Taps      = LfsrTaps,
  parameter int unsigned      ErrThresh = 3,
  parameter int unsigned      CntW      = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  input  logic            in_bit_i,
  output logic            locked_o,
  output logic            err_pulse_o,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [CntW-1:0] bit_count_o,
  output logic [7:0]      resync_count_o,
`endif
  output logic [CntW-1:0] err_count_o
);

  localparam int unsigned SeedW   = $clog2(Width + 1);
  localparam int unsigned ConsecW = $clog2(ErrThresh + 1);

  lfsr_state_e        state_q, state_d;
  logic [SeedW-1:0]   seed_cnt_q, seed_cnt_d;
  logic [ConsecW-1:0] consec_q, consec_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CntW-1:0]    err_count_q, err_count_d;

  logic             shift, clear, use_pred, pred;
  logic [Width-1:0] shadow;
  logic             lose_lock;

  lfsr_pred #(
    .Width (Width),
    .Taps  (Taps)
  ) u_pred (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .shift_i    (shift),
    .clear_i    (clear),
    .use_pred_i (use_pred),
    .bit_i      (in_bit_i),
    .shadow_o   (shadow),
    .pred_o     (pred)
  );

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    consec_d    = consec_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    shift       = 1'b0;
    clear       = 1'b0;
    use_pred    = 1'b0;
    lose_lock   = 1'b0;
    if (in_valid_i) begin
      shift = 1'b1;
      unique case (state_q)
        StSeed: begin
          if (seed_cnt_q == SeedW'(Width - 1)) begin
            seed_cnt_d = '0;
            // An all-zero shadow is the LFSR lockup state and can never be tracked.
            if (|{shadow[Width-2:0], in_bit_i}) begin
              state_d  = StCheck;
              locked_d = 1'b1;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SeedW'(1);
          end
        end
        StCheck: begin
          use_pred = 1'b1;
          if (in_bit_i != pred) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CntW'(1);
            if (consec_q == ConsecW'(ErrThresh - 1)) begin
              lose_lock  = 1'b1;
              state_d    = StSeed;
              locked_d   = 1'b0;
              seed_cnt_d = '0;
              consec_d   = '0;
              shift      = 1'b0;
              clear      = 1'b1;
            end else begin
              consec_d = consec_q + ConsecW'(1);
            end
          end else begin
            consec_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StSeed;
      seed_cnt_q  <= '0;
      consec_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      consec_q    <= consec_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

`ifdef LFSR_CHK_BITCNT_EN
  logic [CntW-1:0] bit_count_q;
  logic [7:0]      resync_count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bit_count_q    <= '0;
      resync_count_q <= '0;
    end else begin
      if (in_valid_i && state_q == StCheck && bit_count_q != '1) begin
        bit_count_q <= bit_count_q + CntW'(1);
      end
      if (lose_lock && resync_count_q != '1) begin
        resync_count_q <= resync_count_q + 8'd1;
      end
    end
  end

  assign bit_count_o    = bit_count_q;
  assign resync_count_o = resync_count_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a sequence-level reference model.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_bit_i = 1'b0;
  logic        locked_o, err_pulse_o;
  logic [15:0] err_count_o;
`ifdef LFSR_CHK_BITCNT_EN
  logic [15:0] bit_count_o;
  logic [7:0]  resync_count_o;
`endif

  lfsr_checker dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_bit_i       (in_bit_i),
    .locked_o       (locked_o),
    .err_pulse_o    (err_pulse_o),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_count_o    (bit_count_o),
    .resync_count_o (resync_count_o),
`endif
    .err_count_o    (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: bits held as a sequence, prediction from the LFSR recurrence.
  int m_locked, m_pulse, m_err, m_consec, m_bitcnt, m_resync;
  int m_seed[$];
  int m_hist[$];

  task automatic model_step(input bit v, input bit b, input bit rst_n);
    if (!rst_n) begin
      m_locked = 0; m_pulse = 0; m_err = 0; m_consec = 0; m_bitcnt = 0; m_resync = 0;
      m_seed.delete(); m_hist.delete();
      return;
    end
    m_pulse = 0;
    if (!v) return;
    if (m_locked == 0) begin
      m_seed.push_back(int'(b));
      if (m_seed.size() == 4) begin
        if (m_seed.sum() != 0) begin
          m_locked = 1;
          m_hist = m_seed;
        end
        m_seed.delete();
      end
    end else begin
      int e;
      if (m_bitcnt < 65535) m_bitcnt++;
      e = m_hist[0] ^ m_hist[1];
      void'(m_hist.pop_front());
      m_hist.push_back(e);
      if (int'(b) != e) begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
        m_consec++;
        if (m_consec == 3) begin
          m_locked = 0;
          m_consec = 0;
          m_hist.delete();
          if (m_resync < 255) m_resync++;
        end
      end else begin
        m_consec = 0;
      end
    end
  endtask

  logic [3:0] gen;

  function automatic bit gen_step();
    bit nb;
    nb  = lfsr_next_bit(gen, LfsrTaps);
    gen = {gen[2:0], nb};
    return nb;
  endfunction

  task automatic cycle(input bit v, input bit b, input bit rst_n, input string tag);
    @(negedge clk_i);
    in_valid_i = v;
    in_bit_i   = b;
    rst_ni     = rst_n;
    @(posedge clk_i);
    #1;
    model_step(v, b, rst_n);
    check_eq({tag, ".locked"}, 32'(locked_o), 32'(m_locked));
    check_eq({tag, ".err_pulse"}, 32'(err_pulse_o), 32'(m_pulse));
    check_eq({tag, ".err_count"}, 32'(err_count_o), 32'(m_err));
`ifdef LFSR_CHK_BITCNT_EN
    check_eq({tag, ".bit_count"}, 32'(bit_count_o), 32'(m_bitcnt));
    check_eq({tag, ".resync_count"}, 32'(resync_count_o), 32'(m_resync));
`endif
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, "reset");
    gen = LfsrSeed;
  endtask

  initial begin
    int flip_idx;
    bit b;
    do_reset();
    check_eq("reset.locked", 32'(locked_o), 0);
    check_eq("reset.err_count", 32'(err_count_o), 0);

    // Clean stream: lock on the 4th bit, no errors over 60 bits.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, gen_step(), 1'b1, "clean");
      if (i == 2) check_eq("clean.unlocked_3rd", 32'(locked_o), 0);
      if (i == 3) check_eq("clean.locked_4th", 32'(locked_o), 1);
    end
    check_eq("clean.err_total", 32'(err_count_o), 0);

    // Single flip: one error, lock held.
    for (int i = 0; i < 20; i++) begin
      b = gen_step();
      cycle(1'b1, (i == 11) ? ~b : b, 1'b1, "flip");
      if (i == 11) check_eq("flip.pulse", 32'(err_pulse_o), 1);
      if (i == 12) check_eq("flip.pulse_clr", 32'(err_pulse_o), 0);
    end
    check_eq("flip.err_total", 32'(err_count_o), 1);
    check_eq("flip.locked", 32'(locked_o), 1);

    // Burst of 3: lock lost on the 3rd error, regained 4 valid bits later.
    for (int i = 0; i < 12; i++) begin
      b = gen_step();
      cycle(1'b1, (i >= 2 && i <= 4) ? ~b : b, 1'b1, "burst");
      if (i == 3) check_eq("burst.still_locked", 32'(locked_o), 1);
      if (i == 4) check_eq("burst.lost", 32'(locked_o), 0);
      if (i == 7) check_eq("burst.seeding", 32'(locked_o), 0);
      if (i == 8) check_eq("burst.relock", 32'(locked_o), 1);
    end
    check_eq("burst.err_total", 32'(err_count_o), 4);

    // All-zero input never locks.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, "zeros");
    check_eq("zeros.locked", 32'(locked_o), 0);
    check_eq("zeros.err_total", 32'(err_count_o), 0);

    // Valid gaps 1,0,0,1: lock after 4 valid bits, no pulses on invalid cycles.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bit v;
      v = (i % 4 == 0) || (i % 4 == 3);
      cycle(v, v ? gen_step() : 1'($urandom_range(0, 1)), 1'b1, "gaps");
      if (i == 4) check_eq("gaps.unlocked", 32'(locked_o), 0);
      if (i == 7) check_eq("gaps.locked", 32'(locked_o), 1);
    end
    check_eq("gaps.err_total", 32'(err_count_o), 0);

    // Random valids and sparse flips, occasionally bursty.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        b = gen_step();
        if ($urandom_range(0, 11) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      cycle(v, b, 1'b1, "rand");
    end

    // Reset mid-lock with two errors recorded.
    do_reset();
    flip_idx = 0;
    for (int i = 0; i < 16; i++) begin
      b = gen_step();
      cycle(1'b1, (i == 6 || i == 10) ? ~b : b, 1'b1, "prerst");
    end
    check_eq("prerst.err_total", 32'(err_count_o), 2);
    check_eq("prerst.locked", 32'(locked_o), 1);
    cycle(1'b1, gen_step(), 1'b0, "midrst");
    check_eq("midrst.locked", 32'(locked_o), 0);
    check_eq("midrst.err_count", 32'(err_count_o), 0);
`ifdef LFSR_CHK_BITCNT_EN
    check_eq("midrst.bit_count", 32'(bit_count_o), 0);
    check_eq("midrst.resync_count", 32'(resync_count_o), 0);
`endif
    // After reset it must need a full fresh seed before locking.
    gen = LfsrSeed;
    for (int i = 0; i < 8; i++) cycle(1'b1, gen_step(), 1'b1, "postrst");
    check_eq("postrst.locked", 32'(locked_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
